// File: rtl/bus_dma_copy_if.sv
// Bus between one initiator and one responder (sp_bram or a peripheral).
//
// Handshake: the initiator raises enable with wr_en/addr/wdata/be and holds
// every one of them stable until the responder answers with a single-cycle
// ready. rdata and err are meaningful only in the cycle where ready=1. After
// ready the initiator drops enable for at least one cycle before the next
// request, so a ready never belongs to more than one request.
//
// Signals:
//   enable  initiator -> responder  request valid
//   wr_en   initiator -> responder  1=write, 0=read
//   addr    initiator -> responder  byte address
//   wdata   initiator -> responder  write data (byte writes use lane 0)
//   be      initiator -> responder  4'b1111 word, 4'b0001 byte
//   ready   responder -> initiator  access complete this cycle
//   rdata   responder -> initiator  read data (byte reads right-justified)
//   err     responder -> initiator  access faulted (qualified by ready)
interface bus_dma_copy_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  enable;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [3:0]            be;
  logic                  ready;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  err;

  modport master (
    output enable, wr_en, addr, wdata, be,
    input  ready, rdata, err
  );

  modport slave (
    input  enable, wr_en, addr, wdata, be,
    output ready, rdata, err
  );
endinterface

// File: rtl/bus_dma_copy.sv
// Block copy engine acting as bus initiator. Copies i_len bytes from i_src to
// i_dst as read/write pairs, using word accesses when both addresses are word
// aligned and at least four bytes remain, byte accesses otherwise. Aborts on
// a bus error or when a request waits TIMEOUT cycles without ready.
//
// Optional feature macro: BUS_DMA_FILL_EN
//   When defined, a start with i_fill=1 skips reads and writes i_pattern
//   (word writes) or i_pattern[7:0] (byte writes) to the destination.
//   When undefined, i_fill and i_pattern are ignored.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   i_start       1-cycle request, sampled only when idle
//   i_src/i_dst   source/destination byte address (latched on start)
//   i_len         byte count (latched on start)
//   i_fill        fill-mode select
//   i_pattern     fill word
//   o_busy        transfer in progress
//   o_done        1-cycle pulse on successful completion
//   o_err         sticky abort flag, cleared by the next accepted start
//   o_err_addr    address of the faulting access
//   o_dbg_state   current FSM state
//   bus           initiator side of bus_dma_copy_if
module bus_dma_copy #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_src,
  input  logic [ADDR_WIDTH-1:0] i_dst,
  input  logic [LEN_WIDTH-1:0]  i_len,
  input  logic                  i_fill,
  input  logic [DATA_WIDTH-1:0] i_pattern,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  output logic [ADDR_WIDTH-1:0] o_err_addr,
  output logic [2:0]            o_dbg_state,
  bus_dma_copy_if.master        bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_REQ, S_RD_GAP, S_WR_REQ, S_WR_GAP, S_DONE, S_ERR
  } state_t;

  // Counter only has to reach TIMEOUT-1; the abort happens on that cycle.
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_src;
  logic [ADDR_WIDTH-1:0] r_dst;
  logic [LEN_WIDTH-1:0]  r_rem;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_word;
  logic [TW-1:0]         r_tmo;

  logic                  w_fill_start;
  logic [DATA_WIDTH-1:0] w_pat_start;
  logic                  w_fill_mode;
  logic [DATA_WIDTH-1:0] w_pat;
  logic                  w_word_start;
  logic                  w_word_cont;
  logic                  w_tmo_hit;
  logic [LEN_WIDTH-1:0]  w_step_len;
  logic [ADDR_WIDTH-1:0] w_step_addr;

`ifdef BUS_DMA_FILL_EN
  logic                  r_fill;
  logic [DATA_WIDTH-1:0] r_pattern;
  assign w_fill_start = i_fill;
  assign w_pat_start  = i_pattern;
  assign w_fill_mode  = r_fill;
  assign w_pat        = r_pattern;
`else
  logic w_unused_fill;
  assign w_unused_fill = ^{i_fill, i_pattern};
  assign w_fill_start  = 1'b0;
  assign w_pat_start   = '0;
  assign w_fill_mode   = 1'b0;
  assign w_pat         = '0;
`endif

  // Word access only when both sides are aligned and a full word remains;
  // in fill mode there is no source, so only the destination matters.
  function automatic logic pick_word(input logic [ADDR_WIDTH-1:0] s,
                                     input logic [ADDR_WIDTH-1:0] d,
                                     input logic [LEN_WIDTH-1:0]  rem,
                                     input logic                  fill);
    return (fill || s[1:0] == 2'b00) && (d[1:0] == 2'b00) && (rem >= LEN_WIDTH'(4));
  endfunction

  function automatic logic [DATA_WIDTH-1:0] lane0(input logic [DATA_WIDTH-1:0] x);
    return {{(DATA_WIDTH-8){1'b0}}, x[7:0]};
  endfunction

  assign w_word_start = pick_word(i_src, i_dst, i_len, w_fill_start);
  assign w_word_cont  = pick_word(r_src, r_dst, r_rem, w_fill_mode);
  assign w_tmo_hit    = (r_tmo == TW'(TIMEOUT - 1));
  assign w_step_len   = r_word ? LEN_WIDTH'(4) : LEN_WIDTH'(1);
  assign w_step_addr  = r_word ? ADDR_WIDTH'(4) : ADDR_WIDTH'(1);
  assign o_dbg_state  = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_src      <= '0;
      r_dst      <= '0;
      r_rem      <= '0;
      r_data     <= '0;
      r_word     <= 1'b0;
      r_tmo      <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_err      <= 1'b0;
      o_err_addr <= '0;
      bus.enable <= 1'b0;
      bus.wr_en  <= 1'b0;
      bus.addr   <= '0;
      bus.wdata  <= '0;
      bus.be     <= 4'b0000;
`ifdef BUS_DMA_FILL_EN
      r_fill     <= 1'b0;
      r_pattern  <= '0;
`endif
    end else begin
      o_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_src <= i_src;
            r_dst <= i_dst;
            r_rem <= i_len;
            o_err <= 1'b0;
`ifdef BUS_DMA_FILL_EN
            r_fill    <= i_fill;
            r_pattern <= i_pattern;
`endif
            if (i_len == '0) begin
              o_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              o_busy     <= 1'b1;
              r_word     <= w_word_start;
              r_tmo      <= '0;
              bus.enable <= 1'b1;
              bus.be     <= w_word_start ? 4'b1111 : 4'b0001;
              if (w_fill_start) begin
                bus.wr_en <= 1'b1;
                bus.addr  <= i_dst;
                bus.wdata <= w_word_start ? w_pat_start : lane0(w_pat_start);
                r_state   <= S_WR_REQ;
              end else begin
                bus.wr_en <= 1'b0;
                bus.addr  <= i_src;
                r_state   <= S_RD_REQ;
              end
            end
          end
        end

        S_RD_REQ: begin
          if (bus.ready) begin
            r_data     <= bus.rdata;
            bus.enable <= 1'b0;
            if (bus.err) begin
              o_err      <= 1'b1;
              o_busy     <= 1'b0;
              o_err_addr <= bus.addr;
              r_state    <= S_ERR;
            end else begin
              r_state <= S_RD_GAP;
            end
          end else if (w_tmo_hit) begin
            bus.enable <= 1'b0;
            o_err      <= 1'b1;
            o_busy     <= 1'b0;
            o_err_addr <= bus.addr;
            r_state    <= S_ERR;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end

        S_RD_GAP: begin
          r_tmo      <= '0;
          bus.enable <= 1'b1;
          bus.wr_en  <= 1'b1;
          bus.addr   <= r_dst;
          bus.wdata  <= r_word ? r_data : lane0(r_data);
          r_state    <= S_WR_REQ;
        end

        S_WR_REQ: begin
          if (bus.ready) begin
            bus.enable <= 1'b0;
            if (bus.err) begin
              o_err      <= 1'b1;
              o_busy     <= 1'b0;
              o_err_addr <= bus.addr;
              r_state    <= S_ERR;
            end else begin
              r_src   <= r_src + w_step_addr;
              r_dst   <= r_dst + w_step_addr;
              r_rem   <= r_rem - w_step_len;
              r_state <= S_WR_GAP;
            end
          end else if (w_tmo_hit) begin
            bus.enable <= 1'b0;
            o_err      <= 1'b1;
            o_busy     <= 1'b0;
            o_err_addr <= bus.addr;
            r_state    <= S_ERR;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end

        S_WR_GAP: begin
          if (r_rem == '0) begin
            o_busy  <= 1'b0;
            o_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_word     <= w_word_cont;
            r_tmo      <= '0;
            bus.enable <= 1'b1;
            bus.be     <= w_word_cont ? 4'b1111 : 4'b0001;
            if (w_fill_mode) begin
              bus.wr_en <= 1'b1;
              bus.addr  <= r_dst;
              bus.wdata <= w_word_cont ? w_pat : lane0(w_pat);
              r_state   <= S_WR_REQ;
            end else begin
              bus.wr_en <= 1'b0;
              bus.addr  <= r_src;
              r_state   <= S_RD_REQ;
            end
          end
        end

        S_DONE:  r_state <= S_IDLE;
        S_ERR:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
